i2c_slave_regfile: RTL and testbench

Parametrised I2C target (7-bit addressing) with an internal register file of NUM_REGS bytes, an auto-incrementing register pointer, multi-byte burst read/write, repeated-START support and a host-side port for the local logic. It sits between the board-level open-drain SCL/SDA pads and the local control logic. It replaces the fixed single-byte target with a configurable, glitch-filtered, fully ACK/NACK-aware one.

---
 rtl/i2c_slave_regfile.sv | 222 ++++++++++++++++++++++
 tb/tb_i2c_slave_regfile.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_slave_regfile.sv
// I2C target (7-bit address) fronting a byte register file with an
// auto-incrementing pointer, burst read/write and a local host port.
module i2c_slave_regfile #(
  parameter int         NUM_REGS   = 16,
  parameter int         FILTER_LEN = 3,
  parameter logic [7:0] RESET_VAL  = 8'h00,
  localparam int        PTR_W      = (NUM_REGS > 2) ? $clog2(NUM_REGS) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [6:0]       dev_addr,
  input  logic             scl_i,
  input  logic             sda_i,
  output logic             sda_oe,
  input  logic             host_we,
  input  logic [PTR_W-1:0] host_addr,
  input  logic [7:0]       host_wdata,
  output logic [7:0]       host_rdata,
  output logic             wr_strobe,
  output logic [PTR_W-1:0] wr_index,
  output logic             busy
);

  typedef enum logic [3:0] {
    S_IDLE, S_ADDR, S_ADDR_ACK, S_PTR, S_PTR_ACK,
    S_WDATA, S_WDATA_ACK, S_RDATA, S_RDATA_ACK, S_WAIT_STOP
  } state_e;

  // bit 0 = SCL, bit 1 = SDA
  logic [1:0] s1_q, s2_q, filt_q, prev_q;
  logic [3:0] cnt_q [2];

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '1;
      s2_q     <= '1;
      filt_q   <= '1;
      prev_q   <= '1;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q   <= {sda_i, scl_i};
      s2_q   <= s1_q;
      prev_q <= filt_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] == filt_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == 4'(FILTER_LEN - 1)) begin
          filt_q[i] <= s2_q[i];
          cnt_q[i]  <= '0;
        end else begin
          cnt_q[i] <= cnt_q[i] + 4'd1;
        end
      end
    end
  end

  logic scl_f, sda_f, scl_p, sda_p;
  logic scl_rise, scl_fall, start_c, stop_c;

  assign scl_f    = filt_q[0];
  assign sda_f    = filt_q[1];
  assign scl_p    = prev_q[0];
  assign sda_p    = prev_q[1];
  assign scl_rise = scl_f & ~scl_p;
  assign scl_fall = ~scl_f & scl_p;
  assign start_c  = scl_f & scl_p & sda_p & ~sda_f;
  assign stop_c   = scl_f & scl_p & ~sda_p & sda_f;

  state_e           state_q;
  logic [3:0]       bit_q;
  logic [7:0]       sh_q;
  logic [PTR_W-1:0] ptr_q;
  logic             rw_q, mack_q;
  logic             oe_q, busy_q, strobe_q;
  logic [PTR_W-1:0] idx_q;
  logic [7:0]       regs_q [NUM_REGS];

  logic [7:0]       rx_byte, rd_byte;
  logic [PTR_W-1:0] ptr_inc;
  logic             ptr_ok, host_ok, host_hit;

  assign rx_byte  = {sh_q[6:0], sda_f};
  assign rd_byte  = regs_q[ptr_q];
  assign ptr_inc  = (ptr_q == PTR_W'(NUM_REGS - 1)) ? '0 : ptr_q + 1'b1;
  assign ptr_ok   = {1'b0, rx_byte} < 9'(NUM_REGS);
  assign host_ok  = int'(host_addr) < NUM_REGS;
  assign host_hit = host_we & host_ok & (host_addr == ptr_q);

  assign host_rdata = host_ok ? regs_q[host_addr] : '0;
  assign sda_oe     = oe_q;
  assign busy       = busy_q;
  assign wr_strobe  = strobe_q;
  assign wr_index   = idx_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      bit_q    <= '0;
      sh_q     <= '0;
      ptr_q    <= '0;
      rw_q     <= 1'b0;
      mack_q   <= 1'b0;
      oe_q     <= 1'b0;
      busy_q   <= 1'b0;
      strobe_q <= 1'b0;
      idx_q    <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      strobe_q <= 1'b0;
      if (host_we && host_ok) regs_q[host_addr] <= host_wdata;
      if (start_c) begin
        state_q <= S_ADDR;
        bit_q   <= '0;
      end else if (stop_c) begin
        state_q <= S_IDLE;
        oe_q    <= 1'b0;
        busy_q  <= 1'b0;
      end else begin
        unique case (state_q)
          S_ADDR: if (scl_rise) begin
            sh_q  <= rx_byte;
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              if (rx_byte[7:1] == dev_addr) begin
                state_q <= S_ADDR_ACK;
                busy_q  <= 1'b1;
                rw_q    <= rx_byte[0];
              end else begin
                state_q <= S_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end
          end
          S_PTR: if (scl_rise) begin
            sh_q  <= rx_byte;
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              if (ptr_ok) begin
                ptr_q   <= rx_byte[PTR_W-1:0];
                state_q <= S_PTR_ACK;
              end else begin
                state_q <= S_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end
          end
          S_WDATA: if (scl_rise) begin
            sh_q  <= rx_byte;
            bit_q <= bit_q + 4'd1;
            if (bit_q == 4'd7) begin
              if (!host_hit) regs_q[ptr_q] <= rx_byte;
              strobe_q <= 1'b1;
              idx_q    <= ptr_q;
              ptr_q    <= ptr_inc;
              state_q  <= S_WDATA_ACK;
            end
          end
          // first fall after bit 8 asserts ACK, second fall releases it
          S_ADDR_ACK: if (scl_fall) begin
            if (!oe_q) begin
              oe_q <= 1'b1;
            end else begin
              bit_q <= '0;
              if (rw_q) begin
                oe_q    <= ~rd_byte[7];
                sh_q    <= {rd_byte[6:0], 1'b0};
                ptr_q   <= ptr_inc;
                state_q <= S_RDATA;
              end else begin
                oe_q    <= 1'b0;
                state_q <= S_PTR;
              end
            end
          end
          S_PTR_ACK, S_WDATA_ACK: if (scl_fall) begin
            if (!oe_q) begin
              oe_q <= 1'b1;
            end else begin
              oe_q    <= 1'b0;
              bit_q   <= '0;
              state_q <= S_WDATA;
            end
          end
          S_RDATA: begin
            if (scl_rise) bit_q <= bit_q + 4'd1;
            if (scl_fall) begin
              if (bit_q == 4'd8) begin
                oe_q    <= 1'b0;
                mack_q  <= 1'b0;
                state_q <= S_RDATA_ACK;
              end else begin
                oe_q <= ~sh_q[7];
                sh_q <= {sh_q[6:0], 1'b0};
              end
            end
          end
          S_RDATA_ACK: begin
            if (scl_rise) begin
              if (!sda_f) begin
                mack_q <= 1'b1;
              end else begin
                state_q <= S_WAIT_STOP;
                busy_q  <= 1'b0;
              end
            end
            if (scl_fall && mack_q) begin
              oe_q    <= ~rd_byte[7];
              sh_q    <= {rd_byte[6:0], 1'b0};
              ptr_q   <= ptr_inc;
              bit_q   <= '0;
              state_q <= S_RDATA;
            end
          end
          S_IDLE, S_WAIT_STOP: ;
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_slave_regfile.sv
// Directed bench: bit-banged I2C master with open-drain bus model,
// glitch injection and host-port collision checks.
module tb_i2c_slave_regfile;

  localparam int Q = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [6:0] dev_addr = 7'h42;
  logic       scl_m = 1'b1, sda_m = 1'b1;
  logic       scl_g = 1'b0, sda_g = 1'b0;
  logic       glitch = 1'b0;
  logic       scl_i, sda_i, sda_oe;
  logic       host_we = 1'b0;
  logic [3:0] host_addr = '0;
  logic [7:0] host_wdata = '0;
  logic [7:0] host_rdata;
  logic       wr_strobe, busy;
  logic [3:0] wr_index;

  int total = 0;
  int bad = 0;
  int wr_log [$];
  logic oe_seen = 1'b0;

  assign scl_i = scl_m ^ scl_g;
  assign sda_i = (sda_m & ~sda_oe) ^ sda_g;

  always #5 clk = ~clk;

  i2c_slave_regfile dut (
    .clk(clk), .rst(rst), .dev_addr(dev_addr),
    .scl_i(scl_i), .sda_i(sda_i), .sda_oe(sda_oe),
    .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_index(wr_index), .busy(busy)
  );

  always @(negedge clk) begin
    if (wr_strobe) wr_log.push_back(int'(wr_index));
    if (sda_oe) oe_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask

  function automatic int log_at(input int i);
    return (i < wr_log.size()) ? wr_log[i] : -1;
  endfunction

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic chk_reg(input string tag, input int a, input logic [7:0] e);
    host_addr = a[3:0];
    #1;
    chk(tag, host_rdata, e);
  endtask

  task automatic host_wr(input int a, input logic [7:0] d);
    host_addr  = a[3:0];
    host_wdata = d;
    host_we    = 1'b1;
    wait_clk(1);
    host_we    = 1'b0;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b0; wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wait_clk(Q);
    scl_m = 1'b1; wait_clk(2*Q);
    sda_m = 1'b1; wait_clk(2*Q);
  endtask

  task automatic wr_bit(input logic b);
    sda_m = b;
    if (glitch) begin
      wait_clk(2); scl_g = 1'b1; wait_clk(1); scl_g = 1'b0; wait_clk(Q-3);
    end else wait_clk(Q);
    scl_m = 1'b1;
    if (glitch) begin
      wait_clk(Q); sda_g = 1'b1; wait_clk(1); sda_g = 1'b0; wait_clk(Q-1);
    end else wait_clk(2*Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic rd_bit(output logic b);
    sda_m = 1'b1; wait_clk(Q);
    scl_m = 1'b1; wait_clk(Q);
    b = sda_i;    wait_clk(Q);
    scl_m = 1'b0; wait_clk(Q);
  endtask

  task automatic wr_byte(input logic [7:0] d, output logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(b);
    ack = ~b;
  endtask

  task automatic rd_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      rd_bit(b);
      d[i] = b;
    end
    wr_bit(~mack);
  endtask

  // last data bit with a host write to reg[4] held across the commit edge
  task automatic wr_byte_hc(input logic [7:0] d, output logic ack);
    logic b;
    int n;
    for (int i = 7; i >= 1; i--) wr_bit(d[i]);
    sda_m = d[0]; wait_clk(Q);
    host_addr  = 4'd4;
    host_wdata = 8'hE1;
    host_we    = 1'b1;
    scl_m      = 1'b1;
    n = 0;
    while (!wr_strobe && n < 2*Q) begin
      wait_clk(1);
      n++;
    end
    host_we = 1'b0;
    chk("hc_strobe", wr_strobe, 1);
    chk("hc_index", wr_index, 4);
    wait_clk(2*Q - n);
    scl_m = 1'b0; wait_clk(Q);
    rd_bit(b);
    ack = ~b;
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic a;
    logic [7:0] d;
    rst = 1'b1;
    wait_clk(4);
    rst = 1'b0;
    wait_clk(2);
    chk("rst_oe", sda_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_strobe", wr_strobe, 0);
    chk("rst_index", wr_index, 0);
    chk_reg("rst_reg3", 3, 8'h00);
    chk_reg("rst_reg15", 15, 8'h00);

    // burst write at pointer 3
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, a); chk("t1_addr_ack", a, 1);
    chk("t1_busy", busy, 1);
    wr_byte(8'h03, a); chk("t1_ptr_ack", a, 1);
    wr_byte(8'hA5, a); chk("t1_d0_ack", a, 1);
    wr_byte(8'h5A, a); chk("t1_d1_ack", a, 1);
    i2c_stop();
    chk("t1_busy_end", busy, 0);
    chk_reg("t1_reg3", 3, 8'hA5);
    chk_reg("t1_reg4", 4, 8'h5A);
    chk("t1_nstrobe", wr_log.size(), 2);
    chk("t1_idx0", log_at(0), 3);
    chk("t1_idx1", log_at(1), 4);

    // pointer write, repeated START, 3-byte read
    i2c_start();
    wr_byte(8'h84, a);
    wr_byte(8'h02, a);
    wr_byte(8'h77, a); chk("t2_w_ack", a, 1);
    i2c_stop();
    i2c_start();
    wr_byte(8'h84, a);
    wr_byte(8'h02, a); chk("t2_ptr_ack", a, 1);
    i2c_start();
    wr_byte(8'h85, a); chk("t2_raddr_ack", a, 1);
    rd_byte(d, 1'b1); chk("t2_rd0", d, 8'h77);
    rd_byte(d, 1'b1); chk("t2_rd1", d, 8'hA5);
    rd_byte(d, 1'b0); chk("t2_rd2", d, 8'h5A);
    chk("t2_oe_rel", sda_oe, 0);
    chk("t2_busy_nack", busy, 0);
    i2c_stop();
    host_wr(5, 8'hC3);
    i2c_start();
    wr_byte(8'h85, a);
    rd_byte(d, 1'b0); chk("t2_ptr5", d, 8'hC3);
    i2c_stop();

    // pointer wrap 15 -> 0
    wr_log.delete();
    i2c_start();
    wr_byte(8'h84, a);
    wr_byte(8'h0F, a);
    wr_byte(8'h11, a);
    wr_byte(8'h22, a); chk("t3_ack", a, 1);
    i2c_stop();
    chk_reg("t3_reg15", 15, 8'h11);
    chk_reg("t3_reg0", 0, 8'h22);
    chk("t3_idx0", log_at(0), 15);
    chk("t3_idx1", log_at(1), 0);

    // wrong address, then out-of-range pointer
    host_wr(1, 8'h3C);
    oe_seen = 1'b0;
    i2c_start();
    wr_byte(8'h86, a); chk("t4_addr_nack", a, 0);
    chk("t4_busy", busy, 0);
    wr_byte(8'hFF, a); chk("t4_data_nack", a, 0);
    i2c_stop();
    chk("t4_oe_quiet", oe_seen, 0);
    chk_reg("t4_reg0", 0, 8'h22);
    chk_reg("t4_reg15", 15, 8'h11);
    i2c_start();
    wr_byte(8'h84, a); chk("t4_addr_ack", a, 1);
    wr_byte(8'h10, a); chk("t4_ptr_nack", a, 0);
    chk("t4_busy_nack", busy, 0);
    i2c_stop();
    i2c_start();
    wr_byte(8'h85, a);
    rd_byte(d, 1'b0); chk("t4_ptr_kept", d, 8'h3C);
    i2c_stop();

    // one-clock glitches on both lines
    glitch = 1'b1;
    i2c_start();
    wr_byte(8'h84, a); chk("t5_addr_ack", a, 1);
    wr_byte(8'h06, a); chk("t5_ptr_ack", a, 1);
    wr_byte(8'h96, a); chk("t5_data_ack", a, 1);
    glitch = 1'b0;
    i2c_stop();
    chk_reg("t5_reg6", 6, 8'h96);

    // host write collides with I2C commit
    i2c_start();
    wr_byte(8'h84, a);
    wr_byte(8'h04, a);
    wr_byte_hc(8'h12, a); chk("t6_ack", a, 1);
    i2c_stop();
    chk_reg("t6_reg4", 4, 8'hE1);

    // reset while driving read data
    host_wr(8, 8'h0F);
    i2c_start();
    wr_byte(8'h84, a);
    wr_byte(8'h08, a);
    i2c_start();
    wr_byte(8'h85, a);
    wait_clk(2);
    chk("t7_oe_drv", sda_oe, 1);
    rst = 1'b1;
    wait_clk(1);
    chk("t7_oe_rst", sda_oe, 0);
    chk("t7_busy_rst", busy, 0);
    scl_m = 1'b1;
    sda_m = 1'b1;
    wait_clk(6);
    rst = 1'b0;
    wait_clk(Q);
    chk_reg("t7_reg3", 3, 8'h00);
    chk_reg("t7_reg8", 8, 8'h00);
    i2c_start();
    wr_byte(8'h84, a); chk("t7_addr_ack", a, 1);
    wr_byte(8'h09, a);
    wr_byte(8'h5C, a); chk("t7_data_ack", a, 1);
    i2c_stop();
    chk_reg("t7_reg9", 9, 8'h5C);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
